// File: rtl/fb_bank_sched.sv
// fb_bank_sched
// Arbitrates one single-port frame-buffer RAM between the downsampled-pixel
// writer and the recognition-engine reader, with ping-pong double buffering.
// The writer always fills bank oWBANK and the reader always reads bank
// ~oWBANK. A write takes priority over a read in the same cycle, and a read
// uses any cycle that has no write.
//
// Ports:
//   iCLK, iRESET        clock, asynchronous active-high reset
//   iWR_EN/ADDR/DATA    pixel write from the downsampler
//   iRD_REQ/ADDR        read request (level, held until oRD_GNT)
//   iRD_DONE            reader has finished with its frame (1-cycle pulse)
//   oRD_GNT             read accepted this cycle
//   oRD_DVALID/DATA     read return, RD_LAT cycles after the grant
//   oFRAME_START        new frame is ready in the read bank (1-cycle pulse)
//   oRD_BUSY            reader owns a frame
//   oWBANK              bank currently being written
//   oDROP_CNT           dropped-frame count (saturating)
//   oMEM_*/iMEM_Q       RAM port; address is {bank, addr}
module fb_bank_sched #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 76800,
  parameter int RD_LAT      = 2
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iWR_EN,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  input  logic              iRD_DONE,
  output logic              oRD_GNT,
  output logic              oRD_DVALID,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oFRAME_START,
  output logic              oRD_BUSY,
  output logic              oWBANK,
  output logic [15:0]       oDROP_CNT,
  output logic [ADDR_W:0]   oMEM_ADDR,
  output logic              oMEM_WREN,
  output logic [DATA_W-1:0] oMEM_DATA,
  input  logic [DATA_W-1:0] iMEM_Q
);

  localparam logic [1:0] ST_NOFRAME = 2'd0;
  localparam logic [1:0] ST_RD_BUSY = 2'd1;
  localparam logic [1:0] ST_RD_IDLE = 2'd2;

  localparam logic [ADDR_W-1:0] FRAME_C = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(FRAME_WORDS - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              wbank_r;
  logic              busy_r;
  logic              fstart_r;
  logic [15:0]       drop_cnt_r;
  logic [RD_LAT-1:0] vld_pipe_r;
  logic [RD_LAT-1:0] oob_pipe_r;

  logic wr_slot_s;
  logic rd_slot_s;
  logic rd_oob_s;
  logic eof_s;
  logic swap_s;
  logic drop_s;

  // An out-of-range write still occupies the port, so reads key off iWR_EN
  // rather than wr_slot_s.
  assign wr_slot_s = !iRESET && iWR_EN && (iWR_ADDR < FRAME_C);
  assign rd_slot_s = !iRESET && !iWR_EN && iRD_REQ && busy_r;
  assign rd_oob_s  = (iRD_ADDR >= FRAME_C);
  assign eof_s     = iWR_EN && (iWR_ADDR == LAST_C);

  // RAM port mux: write slot first, otherwise a read slot, otherwise idle.
  always_comb begin
    oMEM_ADDR = {(ADDR_W+1){1'b0}};
    oMEM_WREN = 1'b0;
    oMEM_DATA = {DATA_W{1'b0}};
    oRD_GNT   = 1'b0;
    if (wr_slot_s) begin
      oMEM_ADDR = {wbank_r, iWR_ADDR};
      oMEM_WREN = 1'b1;
      oMEM_DATA = iWR_DATA;
    end else if (rd_slot_s) begin
      oMEM_ADDR = {~wbank_r, iRD_ADDR};
      oRD_GNT   = 1'b1;
    end else begin
      oMEM_ADDR = {(ADDR_W+1){1'b0}};
    end
  end

  // Frame-ownership state machine: decides swap, drop and next state.
  always_comb begin
    state_nxt_s = state_r;
    swap_s      = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ST_NOFRAME, ST_RD_IDLE: begin
        if (eof_s) begin
          swap_s      = 1'b1;
          state_nxt_s = ST_RD_BUSY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RD_BUSY: begin
        // A reader release coincident with EOF lets the swap go through.
        if (eof_s && iRD_DONE) begin
          swap_s      = 1'b1;
          state_nxt_s = ST_RD_BUSY;
        end else if (eof_s) begin
          drop_s      = 1'b1;
          state_nxt_s = ST_RD_BUSY;
        end else if (iRD_DONE) begin
          state_nxt_s = ST_RD_IDLE;
        end else begin
          state_nxt_s = ST_RD_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_NOFRAME;
      end
    endcase
  end

  // Bank, ownership, frame-start pulse and drop counter registers.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_r    <= ST_NOFRAME;
      wbank_r    <= 1'b0;
      busy_r     <= 1'b0;
      fstart_r   <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s == ST_RD_BUSY);
      fstart_r <= swap_s;
      if (swap_s) begin
        wbank_r <= ~wbank_r;
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
    end
  end

  // Read-return pipeline; the out-of-range flag travels with each grant.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vld_pipe_r <= {RD_LAT{1'b0}};
      oob_pipe_r <= {RD_LAT{1'b0}};
    end else begin
      vld_pipe_r[0] <= rd_slot_s;
      oob_pipe_r[0] <= rd_slot_s && rd_oob_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        oob_pipe_r[i] <= oob_pipe_r[i-1];
      end
    end
  end

  // Return data: RAM output in the valid cycle, forced to zero otherwise.
  always_comb begin
    oRD_DVALID = vld_pipe_r[RD_LAT-1];
    if (vld_pipe_r[RD_LAT-1] && !oob_pipe_r[RD_LAT-1]) begin
      oRD_DATA = iMEM_Q;
    end else begin
      oRD_DATA = {DATA_W{1'b0}};
    end
  end

  assign oFRAME_START = fstart_r;
  assign oRD_BUSY     = busy_r;
  assign oWBANK       = wbank_r;
  assign oDROP_CNT    = drop_cnt_r;

endmodule

// File: tb/tb_fb_bank_sched.sv
// Directed testbench for fb_bank_sched with a behavioural 2-cycle-latency RAM.
module tb_fb_bank_sched;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        iWR_EN;
  logic [16:0] iWR_ADDR;
  logic [7:0]  iWR_DATA;
  logic        iRD_REQ;
  logic [16:0] iRD_ADDR;
  logic        iRD_DONE;
  logic        oRD_GNT;
  logic        oRD_DVALID;
  logic [7:0]  oRD_DATA;
  logic        oFRAME_START;
  logic        oRD_BUSY;
  logic        oWBANK;
  logic [15:0] oDROP_CNT;
  logic [17:0] oMEM_ADDR;
  logic        oMEM_WREN;
  logic [7:0]  oMEM_DATA;
  logic [7:0]  iMEM_Q;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fb_bank_sched dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR), .iRD_DONE(iRD_DONE),
    .oRD_GNT(oRD_GNT), .oRD_DVALID(oRD_DVALID), .oRD_DATA(oRD_DATA),
    .oFRAME_START(oFRAME_START), .oRD_BUSY(oRD_BUSY), .oWBANK(oWBANK),
    .oDROP_CNT(oDROP_CNT), .oMEM_ADDR(oMEM_ADDR), .oMEM_WREN(oMEM_WREN),
    .oMEM_DATA(oMEM_DATA), .iMEM_Q(iMEM_Q)
  );

  always #5 iCLK = ~iCLK;

  // RAM model: address registered twice, so data appears 2 cycles later.
  logic [7:0]  mem [0:262143];
  logic [17:0] ram_a1;
  logic [17:0] ram_a2;
  always @(posedge iCLK) begin
    if (oMEM_WREN) mem[oMEM_ADDR] <= oMEM_DATA;
    ram_a1 <= oMEM_ADDR;
    ram_a2 <= ram_a1;
  end
  assign iMEM_Q = mem[ram_a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic nxt();
    @(posedge iCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge iCLK);
  endtask

  initial begin
    iRESET = 1'b1; iWR_EN = 1'b0; iWR_ADDR = 17'd0; iWR_DATA = 8'd0;
    iRD_REQ = 1'b0; iRD_ADDR = 17'd0; iRD_DONE = 1'b0;
    repeat (3) @(posedge iCLK);
    smp();
    chk("rst_dvalid", oRD_DVALID, 1'b0);
    chk("rst_gnt", oRD_GNT, 1'b0);
    chk("rst_wren", oMEM_WREN, 1'b0);
    chk("rst_wbank", oWBANK, 1'b0);
    chk("rst_busy", oRD_BUSY, 1'b0);
    chk("rst_drop", oDROP_CNT, 16'd0);
    chk("rst_fstart", oFRAME_START, 1'b0);
    chk("rst_rdata", oRD_DATA, 8'd0);
    nxt(); iRESET = 1'b0;

    // Read request with no frame is never granted.
    iRD_REQ = 1'b1; iRD_ADDR = 17'd5;
    smp(); chk("nofr_gnt", oRD_GNT, 1'b0);

    // Fill bank 0 with data = addr[7:0] for the low addresses.
    for (int a = 0; a < 512; a++) begin
      nxt();
      iWR_EN = 1'b1; iWR_ADDR = 17'(a); iWR_DATA = 8'(a);
      smp();
      chk("fill_wren", oMEM_WREN, 1'b1);
      chk("fill_gnt", oRD_GNT, 1'b0);
      if (a == 300) chk("fill_addr", oMEM_ADDR, 18'd300);
    end

    // Out-of-range write is dropped.
    nxt(); iWR_ADDR = 17'd76800; iWR_DATA = 8'hAA;
    smp();
    chk("oob_wr_wren", oMEM_WREN, 1'b0);
    chk("oob_wr_gnt", oRD_GNT, 1'b0);

    // EOF write lands in the pre-swap bank.
    nxt(); iWR_ADDR = 17'd76799; iWR_DATA = 8'hFF;
    smp();
    chk("eof1_wren", oMEM_WREN, 1'b1);
    chk("eof1_addr", oMEM_ADDR, 18'd76799);
    chk("eof1_wbank_pre", oWBANK, 1'b0);
    chk("eof1_fstart_pre", oFRAME_START, 1'b0);

    // Cycle after EOF: swap visible; write beats the held read request.
    nxt(); iWR_ADDR = 17'd10; iWR_DATA = 8'h55; iRD_REQ = 1'b1; iRD_ADDR = 17'd300;
    smp();
    chk("swap1_fstart", oFRAME_START, 1'b1);
    chk("swap1_wbank", oWBANK, 1'b1);
    chk("swap1_busy", oRD_BUSY, 1'b1);
    chk("prio_gnt", oRD_GNT, 1'b0);
    chk("prio_wren", oMEM_WREN, 1'b1);
    chk("prio_addr", oMEM_ADDR, 18'h2000A);

    // Free slot: read of addr 300 from bank 0.
    nxt(); iWR_EN = 1'b0;
    smp();
    chk("rd_gnt", oRD_GNT, 1'b1);
    chk("rd_addr", oMEM_ADDR, 18'd300);
    chk("rd_wren", oMEM_WREN, 1'b0);
    chk("fstart_pulse_end", oFRAME_START, 1'b0);

    nxt(); iRD_ADDR = 17'd301;
    smp();
    chk("rd2_gnt", oRD_GNT, 1'b1);
    chk("rd_lat_dv0", oRD_DVALID, 1'b0);

    nxt(); iRD_REQ = 1'b0;
    smp();
    chk("rd_dv1", oRD_DVALID, 1'b1);
    chk("rd_data300", oRD_DATA, 8'h2C);
    nxt(); smp();
    chk("rd_dv2", oRD_DVALID, 1'b1);
    chk("rd_data301", oRD_DATA, 8'h2D);
    nxt(); smp();
    chk("rd_dv_end", oRD_DVALID, 1'b0);

    // Out-of-range read returns zero data with a valid pulse.
    nxt(); iRD_REQ = 1'b1; iRD_ADDR = 17'd80000;
    smp(); chk("oob_rd_gnt", oRD_GNT, 1'b1);
    nxt(); iRD_REQ = 1'b0;
    smp(); chk("oob_rd_dv0", oRD_DVALID, 1'b0);
    nxt(); smp();
    chk("oob_rd_dv", oRD_DVALID, 1'b1);
    chk("oob_rd_data", oRD_DATA, 8'h00);

    // Second EOF while reader busy: frame dropped, no swap.
    nxt(); iWR_EN = 1'b1; iWR_ADDR = 17'd76799; iWR_DATA = 8'h11;
    smp(); chk("eof2_addr", oMEM_ADDR, 18'd207871);
    nxt(); iWR_EN = 1'b0;
    smp();
    chk("drop_cnt1", oDROP_CNT, 16'd1);
    chk("drop_wbank", oWBANK, 1'b1);
    chk("drop_fstart", oFRAME_START, 1'b0);
    chk("drop_busy", oRD_BUSY, 1'b1);

    // Reader releases the frame; requests now ignored.
    nxt(); iRD_DONE = 1'b1;
    nxt(); iRD_DONE = 1'b0; iRD_REQ = 1'b1; iRD_ADDR = 17'd7;
    smp();
    chk("idle_busy", oRD_BUSY, 1'b0);
    chk("idle_gnt", oRD_GNT, 1'b0);

    // Third EOF from idle: swap.
    nxt(); iRD_REQ = 1'b0; iWR_EN = 1'b1; iWR_ADDR = 17'd76799;
    nxt(); iWR_EN = 1'b0;
    smp();
    chk("eof3_wbank", oWBANK, 1'b0);
    chk("eof3_fstart", oFRAME_START, 1'b1);
    chk("eof3_busy", oRD_BUSY, 1'b1);
    chk("eof3_drop", oDROP_CNT, 16'd1);
    nxt(); smp();
    chk("eof3_fstart_end", oFRAME_START, 1'b0);

    // EOF coincident with iRD_DONE: swap, stay busy, no drop.
    nxt(); iWR_EN = 1'b1; iWR_ADDR = 17'd76799; iRD_DONE = 1'b1;
    nxt(); iWR_EN = 1'b0; iRD_DONE = 1'b0;
    smp();
    chk("coin_wbank", oWBANK, 1'b1);
    chk("coin_busy", oRD_BUSY, 1'b1);
    chk("coin_drop", oDROP_CNT, 16'd1);
    chk("coin_fstart", oFRAME_START, 1'b1);

    // Reset with two reads in flight.
    nxt(); iRD_REQ = 1'b1; iRD_ADDR = 17'd300;
    smp(); chk("inf1_gnt", oRD_GNT, 1'b1);
    nxt(); iRD_ADDR = 17'd301;
    smp(); chk("inf2_gnt", oRD_GNT, 1'b1);
    nxt(); iRD_REQ = 1'b0; iRESET = 1'b1;
    smp();
    chk("mrst_dvalid", oRD_DVALID, 1'b0);
    chk("mrst_wbank", oWBANK, 1'b0);
    chk("mrst_drop", oDROP_CNT, 16'd0);
    chk("mrst_busy", oRD_BUSY, 1'b0);
    chk("mrst_fstart", oFRAME_START, 1'b0);
    nxt(); iRESET = 1'b0;
    smp(); chk("post_rst_dv", oRD_DVALID, 1'b0);
    nxt(); iRD_REQ = 1'b1; iRD_ADDR = 17'd5;
    smp();
    chk("post_rst_gnt", oRD_GNT, 1'b0);
    chk("post_rst_dv2", oRD_DVALID, 1'b0);
    chk("post_rst_fstart", oFRAME_START, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fb_bank_sched.md
Name: fb_bank_sched

Overview:
- Schedules one single-port on-chip frame-buffer RAM between the downsampled-pixel writer (320x240 grayscale, one write every 4th pixel clock at most) and one read requester (recognition engine).
- Provides ping-pong double buffering. Writer and reader always use opposite banks.
- Banks swap only on a writer end-of-frame, and only while the reader is free.
- Writes have absolute priority. Reads use the free port slots.

Parameters:
- ADDR_W, 17: per-bank pixel address width.
- DATA_W, 8: pixel width.
- FRAME_WORDS, 76800: pixels per frame (320*240).
- RD_LAT, 2: RAM read latency in cycles, from address to iMEM_Q valid.

Ports:
- iCLK  in  1  system/pixel clock.
- iRESET  in  1  asynchronous, active-high reset.
- iWR_EN  in  1  write strobe from the downsampler.
- iWR_ADDR  in  ADDR_W  write address, 0..FRAME_WORDS-1.
- iWR_DATA  in  DATA_W  write pixel.
- iRD_REQ  in  1  read request, level; held until granted.
- iRD_ADDR  in  ADDR_W  read address.
- iRD_DONE  in  1  one-cycle pulse: reader has finished with the current frame.
- oRD_GNT  out  1  read accepted this cycle.
- oRD_DVALID  out  1  oRD_DATA valid.
- oRD_DATA  out  DATA_W  read pixel.
- oFRAME_START  out  1  one-cycle pulse: a new frame is ready in the read bank.
- oRD_BUSY  out  1  reader owns a frame.
- oWBANK  out  1  bank currently being written.
- oDROP_CNT  out  16  count of frames dropped; saturates at 0xFFFF.
- oMEM_ADDR  out  ADDR_W+1  RAM address {bank, addr}.
- oMEM_WREN  out  1  RAM write enable.
- oMEM_DATA  out  DATA_W  RAM write data.
- iMEM_Q  in  DATA_W  RAM read data.

Behaviour:
- Reset values: all outputs 0, and state = NOFRAME. iRESET clears the read-valid pipeline, so in-flight reads are discarded. No pulse is emitted after reset.
- Port mux is combinational.
  - Write slot: iWR_EN=1 and iWR_ADDR<FRAME_WORDS. Then oMEM_WREN=1, oMEM_ADDR={oWBANK,iWR_ADDR}, oMEM_DATA=iWR_DATA, oRD_GNT=0.
  - Out-of-range write: oMEM_WREN=0 and the write is dropped. The port counts as busy that cycle.
  - Read slot: no write this cycle, iRD_REQ=1 and oRD_BUSY=1. Then oRD_GNT=1, oMEM_ADDR={~oWBANK,iRD_ADDR}, oMEM_WREN=0.
  - Read requests when oRD_BUSY=0 are never granted.
- Read return:
  - oRD_DVALID is exactly RD_LAT cycles after oRD_GNT, via a shift register. oRD_DATA=iMEM_Q in that cycle.
  - If the granted iRD_ADDR>=FRAME_WORDS, oRD_DVALID still pulses, but oRD_DATA=0.
  - Back-to-back grants give back-to-back valids.
  - A bank swap never affects reads already in flight, because the bank is fixed at grant time.
- EOF is defined as iWR_EN && iWR_ADDR==FRAME_WORDS-1. The EOF write itself goes to the pre-swap oWBANK.
- A swap is a register update on the EOF clock edge: oWBANK<=~oWBANK, oFRAME_START<=1 for the next cycle, oRD_BUSY<=1.
- State machine (registered):
  - NOFRAME: oRD_BUSY=0. EOF -> swap -> RD_BUSY.
  - RD_BUSY: oRD_BUSY=1.
    - iRD_DONE alone -> RD_IDLE.
    - EOF alone -> no swap, oDROP_CNT+1 (saturating). The writer overwrites its own bank.
    - EOF and iRD_DONE in the same cycle -> swap, stay in RD_BUSY, no drop.
  - RD_IDLE: oRD_BUSY=0. EOF -> swap -> RD_BUSY. iRD_DONE is ignored.
  - iRD_DONE in NOFRAME or RD_IDLE: ignored.
- oFRAME_START never asserts without a bank flip. oWBANK changes only on a swap.
- Throughput: with the downsampler duty (1 write in 4 clocks, none on odd lines), each read waits at most 1 cycle. There is no starvation counter.

Test Plan:
- Reset mid-frame with 2 reads in flight (RD_LAT=2) -> no oRD_DVALID afterwards; oWBANK=0, oDROP_CNT=0, state NOFRAME.
- Write addrs 0..76799 to bank 0 with data=addr[7:0] -> at EOF+1: oFRAME_START=1, oWBANK=1, oRD_BUSY=1. Then read addr 300 -> oRD_DVALID 2 cycles after grant with oRD_DATA=0x2C.
- iRD_REQ held and iWR_EN=1 on the same cycle -> oRD_GNT=0, oMEM_WREN=1. Next cycle with no write -> oRD_GNT=1 and oMEM_ADDR={1'b0,iRD_ADDR}.
- Second EOF while reader busy -> no swap, oDROP_CNT=1, oWBANK unchanged. Then iRD_DONE followed by a third EOF -> swap, oWBANK toggles, oFRAME_START pulses.
- iRD_DONE coincident with EOF -> swap, oRD_BUSY stays 1, oDROP_CNT unchanged.
- Write to addr 76800 -> oMEM_WREN=0. Read of addr 80000 -> oRD_DVALID with oRD_DATA=0. iRD_REQ in NOFRAME -> never granted.
